// File: rtl/demux_alulogic_regs.sv
// -----------------------------------------------------------------------------
// demux_alulogic_regs
// 1-to-4 registered demultiplexer. A single ALU/logic result is captured into
// one of four holding registers, either as a single load (slot chosen by
// selector) or as a 4-word burst that fills slots 0..3 on consecutive edges.
// Per-slot valid flags track unconsumed data.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   selector       destination slot for a single load
//   data_in        value to capture
//   load           single-word write of data_in into slot[selector] (IDLE only)
//   burst          start a 4-word burst (IDLE only, wins over load)
//   consume        per-slot read acknowledge, clears valid[i]
//   data_out_0..3  holding registers
//   valid          valid[i]=1 while slot i holds unconsumed data
//   busy           high while the burst FSM is in BURST
//   done           one-cycle pulse after the last burst word is written
//   overwrite_err  (only with DEMUX_OVERWRITE_ERR_EN) sticky flag, set when a
//                  write lands on a valid, unconsumed slot; cleared by reset
//
// Build option
//   DEMUX_OVERWRITE_ERR_EN  adds the overwrite_err output and its detector.
//
// FSM states
//   state | meaning
//   IDLE  | accepts single loads; burst=1 writes slot 0 and enters BURST
//   BURST | writes data_in to slot[burst_cnt] each edge, slots 1..3
// -----------------------------------------------------------------------------
module demux_alulogic_regs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       selector,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   input  logic             burst,
   input  logic [3:0]       consume,
   output logic [WIDTH-1:0] data_out_0,
   output logic [WIDTH-1:0] data_out_1,
   output logic [WIDTH-1:0] data_out_2,
   output logic [WIDTH-1:0] data_out_3,
   output logic [3:0]       valid,
`ifdef DEMUX_OVERWRITE_ERR_EN
   output logic             overwrite_err,
`endif
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state;
   logic [1:0]       burst_cnt;
   logic [WIDTH-1:0] slot_q [4];

   logic             wr_en;
   logic [1:0]       wr_slot;
   logic [3:0]       wr_mask;

   // Write arbitration: in IDLE burst beats load; in BURST the counter owns
   // the destination and selector/load are ignored.
   always_comb begin
      wr_en   = 1'b0;
      wr_slot = selector;
      if (state == IDLE) begin
         if (burst) begin
            wr_en   = 1'b1;
            wr_slot = 2'd0;
         end else if (load) begin
            wr_en   = 1'b1;
            wr_slot = selector;
         end
      end else begin
         wr_en   = 1'b1;
         wr_slot = burst_cnt;
      end
      wr_mask = wr_en ? (4'b0001 << wr_slot) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         burst_cnt <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         done <= 1'b0;

         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
               slot_q[i] <= data_in;
            end
         end
         // A write to a slot being consumed at the same edge keeps it valid.
         valid <= (valid & ~consume) | wr_mask;

         case (state)
            IDLE: begin
               if (burst) begin
                  state     <= BURST;
                  burst_cnt <= 2'd1;
                  busy      <= 1'b1;
               end
            end
            BURST: begin
               burst_cnt <= burst_cnt + 2'd1;
               if (burst_cnt == 2'd3) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               burst_cnt <= 2'd0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEMUX_OVERWRITE_ERR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         overwrite_err <= 1'b0;
      end else if (|(wr_mask & valid & ~consume)) begin
         overwrite_err <= 1'b1;
      end
   end
`endif

   assign data_out_0 = slot_q[0];
   assign data_out_1 = slot_q[1];
   assign data_out_2 = slot_q[2];
   assign data_out_3 = slot_q[3];

endmodule

// File: tb/tb_demux_alulogic_regs.sv
module tb_demux_alulogic_regs;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   selector;
   logic [W-1:0] data_in;
   logic         load;
   logic         burst;
   logic [3:0]   consume;
   logic [W-1:0] data_out_0, data_out_1, data_out_2, data_out_3;
   logic [3:0]   valid;
   logic         busy;
   logic         done;
`ifdef DEMUX_OVERWRITE_ERR_EN
   logic         overwrite_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   demux_alulogic_regs #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .selector   (selector),
      .data_in    (data_in),
      .load       (load),
      .burst      (burst),
      .consume    (consume),
      .data_out_0 (data_out_0),
      .data_out_1 (data_out_1),
      .data_out_2 (data_out_2),
      .data_out_3 (data_out_3),
      .valid      (valid),
`ifdef DEMUX_OVERWRITE_ERR_EN
      .overwrite_err (overwrite_err),
`endif
      .busy       (busy),
      .done       (done)
   );

   // ---------------- behavioural reference model ----------------
   logic [W-1:0] m_data [4];
   logic [3:0]   m_valid;
   int           m_next;     // 0: no burst in progress, else next burst slot
   logic         m_done;
   logic         m_err;

   // Apply the rules for the inputs currently driven, as of the coming edge.
   function automatic void model_edge();
      int target;
      if (reset) begin
         for (int i = 0; i < 4; i++) m_data[i] = '0;
         m_valid = 4'b0000;
         m_next  = 0;
         m_done  = 1'b0;
         m_err   = 1'b0;
         return;
      end
      target = -1;
      if (m_next == 0) begin
         if (burst)     target = 0;
         else if (load) target = int'(selector);
      end else begin
         target = m_next;
      end
      m_valid = m_valid & ~consume;
      if (target >= 0) begin
         if (dut_valid_before(target) && !consume[target]) m_err = 1'b1;
         m_data[target]  = data_in;
         m_valid[target] = 1'b1;
      end
      m_done = (m_next == 3);
      if (m_next == 0) m_next = burst ? 1 : 0;
      else             m_next = (m_next == 3) ? 0 : m_next + 1;
   endfunction

   logic [3:0] m_valid_prev;
   function automatic bit dut_valid_before(int s);
      return m_valid_prev[s];
   endfunction

   function automatic logic [4*W+5:0] exp_vec();
      return {m_data[3], m_data[2], m_data[1], m_data[0], m_valid,
              logic'(m_next != 0), m_done};
   endfunction

   wire [4*W+5:0] act_vec = {data_out_3, data_out_2, data_out_1, data_out_0,
                             valid, busy, done};

   task automatic tick();
      m_valid_prev = m_valid;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; load = 1'b0; burst = 1'b0; consume = 4'b0000;
      selector = 2'd0; data_in = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      for (int i = 0; i < 6; i++) begin
         load = 1'b1; selector = 2'($urandom_range(3)); data_in = $urandom;
         tick();
      end
      load = 1'b0; burst = 1'b1; data_in = $urandom;
      tick();
      burst = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if (act_vec !== '0) begin
         bad++;
         $display("FAIL reset_state: got %h want 0", act_vec);
      end
`ifdef DEMUX_OVERWRITE_ERR_EN
      total++;
      if (overwrite_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_err: got %b want 0", overwrite_err);
      end
`endif
   endtask

   task automatic test_single();
      do_reset();
      load = 1'b1; selector = 2'd2; data_in = 32'hDEADBEEF;
      tick();
      load = 1'b0;
      total++;
      if (data_out_2 !== 32'hDEADBEEF || valid !== 4'b0100 ||
          data_out_0 !== '0 || data_out_1 !== '0 || data_out_3 !== '0) begin
         bad++;
         $display("FAIL single_load: got d2=%h v=%b want DEADBEEF 0100", data_out_2, valid);
      end
      consume = 4'b0100;
      tick();
      consume = 4'b0000;
      total++;
      if (valid !== 4'b0000 || data_out_2 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_consume: got d2=%h v=%b want DEADBEEF 0000", data_out_2, valid);
      end
      // remaining slots, checked against the model
      for (int s = 0; s < 4; s++) begin
         load = 1'b1; selector = 2'(s); data_in = $urandom;
         tick();
         total++;
         if (act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL single_slot%0d: got %h want %h", s, act_vec, exp_vec());
         end
      end
      load = 1'b0;
   endtask

   task automatic test_burst();
      int busy_cnt, done_cnt;
      logic [W-1:0] words [4];
      words[0] = 32'd11; words[1] = 32'd22; words[2] = 32'd33; words[3] = 32'd44;
      do_reset();
      busy_cnt = 0; done_cnt = 0;
      burst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data_in = words[k];
         if (k > 0) begin load = 1'b1; selector = 2'd0; end
         tick();
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         total++;
         if (act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL burst_word%0d: got %h want %h", k, act_vec, exp_vec());
         end
      end
      burst = 1'b0; load = 1'b0;
      total++;
      if (data_out_0 !== 32'd11 || data_out_1 !== 32'd22 || data_out_2 !== 32'd33 ||
          data_out_3 !== 32'd44 || valid !== 4'b1111 || done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL burst_final: got %h %h %h %h v=%b busy=%b done=%b want 11 22 33 44 1111 0 1",
                  data_out_0, data_out_1, data_out_2, data_out_3, valid, busy, done);
      end
      tick();
      done_cnt += int'(done);
      total++;
      if (busy_cnt != 3 || done_cnt != 1) begin
         bad++;
         $display("FAIL burst_timing: got busy_cycles=%0d done_pulses=%0d want 3 1", busy_cnt, done_cnt);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      load = 1'b1; burst = 1'b1; selector = 2'd3; data_in = 32'hA5A5_0001;
      tick();
      load = 1'b0; burst = 1'b0;
      total++;
      if (busy !== 1'b1 || data_out_0 !== 32'hA5A5_0001 || valid !== 4'b0001) begin
         bad++;
         $display("FAIL load_burst_prio: got busy=%b d0=%h v=%b want 1 A5A50001 0001", busy, data_out_0, valid);
      end
      for (int k = 0; k < 4; k++) tick();
      // write and consume on the same slot, plus consume of another slot
      load = 1'b1; selector = 2'd1; data_in = 32'h1234_5678; consume = 4'b1010;
      tick();
      load = 1'b0; consume = 4'b0000;
      total++;
      if (valid !== 4'b0111 || data_out_1 !== 32'h1234_5678) begin
         bad++;
         $display("FAIL write_vs_consume: got v=%b d1=%h want 0111 12345678", valid, data_out_1);
      end
      total++;
      if (act_vec !== exp_vec()) begin
         bad++;
         $display("FAIL simul_model: got %h want %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_reset_mid_burst();
      int done_seen;
      do_reset();
      burst = 1'b1; data_in = 32'hB0;
      tick();
      burst = 1'b0; data_in = 32'hB1;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      done_seen = int'(done);
      total++;
      if (act_vec !== '0) begin
         bad++;
         $display("FAIL mid_burst_reset: got %h want 0", act_vec);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         done_seen += int'(done);
      end
      total++;
      if (done_seen != 0 || busy !== 1'b0 || valid !== 4'b0000) begin
         bad++;
         $display("FAIL mid_burst_quiet: got done_pulses=%0d busy=%b v=%b want 0 0 0000", done_seen, busy, valid);
      end
      burst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data_in = 32'hC0 + k;
         tick();
         burst = 1'b0;
      end
      total++;
      if (act_vec !== exp_vec() || valid !== 4'b1111 || done !== 1'b1) begin
         bad++;
         $display("FAIL fresh_burst: got %h want %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(59) == 0);
         load     = $urandom_range(1);
         burst    = ($urandom_range(7) == 0);
         selector = 2'($urandom_range(3));
         data_in  = $urandom;
         consume  = 4'($urandom & $urandom);
         tick();
         total++;
         if (act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL random_cycle%0d: got %h want %h", n, act_vec, exp_vec());
         end
`ifdef DEMUX_OVERWRITE_ERR_EN
         total++;
         if (overwrite_err !== m_err) begin
            bad++;
            $display("FAIL random_err%0d: got %b want %b", n, overwrite_err, m_err);
         end
`endif
      end
      idle_inputs();
   endtask

`ifdef DEMUX_OVERWRITE_ERR_EN
   task automatic test_overwrite_err();
      do_reset();
      load = 1'b1; selector = 2'd1; data_in = 32'h1;
      tick();
      total++;
      if (overwrite_err !== 1'b0) begin
         bad++;
         $display("FAIL ovr_first: got %b want 0", overwrite_err);
      end
      data_in = 32'h2;
      tick();
      load = 1'b0;
      total++;
      if (overwrite_err !== 1'b1) begin
         bad++;
         $display("FAIL ovr_second: got %b want 1", overwrite_err);
      end
      consume = 4'b1111;
      tick(); tick();
      consume = 4'b0000;
      total++;
      if (overwrite_err !== 1'b1) begin
         bad++;
         $display("FAIL ovr_sticky: got %b want 1", overwrite_err);
      end
      do_reset();
      load = 1'b1; selector = 2'd1; data_in = 32'h3;
      tick();
      load = 1'b0; consume = 4'b0010;
      tick();
      consume = 4'b0000; load = 1'b1; data_in = 32'h4;
      tick();
      consume = 4'b0010; data_in = 32'h5;
      tick();
      load = 1'b0; consume = 4'b0000;
      total++;
      if (overwrite_err !== 1'b0 || data_out_1 !== 32'h5 || valid !== 4'b0010) begin
         bad++;
         $display("FAIL ovr_clean: got err=%b d1=%h v=%b want 0 5 0010", overwrite_err, data_out_1, valid);
      end
   endtask
`endif

   initial begin
      idle_inputs();
      m_valid = 4'b0000; m_valid_prev = 4'b0000;
      m_next = 0; m_done = 1'b0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_data[i] = '0;
      #2;
      test_reset();
      test_single();
      test_burst();
      test_simultaneous();
      test_reset_mid_burst();
      test_random();
`ifdef DEMUX_OVERWRITE_ERR_EN
      test_overwrite_err();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/demux_alulogic_regs.md
Name: demux_aluLogic_regs

Overview:
- 1-to-4 registered demultiplexer: the distribution counterpart of the 4:1 result mux.
- Captures one 32-bit ALU/logic result and routes it into one of four holding registers (Data_out_0..3) chosen by a 2-bit selector.
- Per-slot valid flags let the control unit track which slots hold fresh data.
- A burst mode fills all four slots on consecutive cycles under a small FSM.

Parameters:
- WIDTH, 32, data width of the input and of each holding register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- selector  input  2  destination slot for a single load (0..3).
- Data_in  input  WIDTH  value to capture.
- load  input  1  single-word write of Data_in into slot[selector].
- burst  input  1  start a 4-word burst; ignored unless state is IDLE.
- consume  input  4  per-slot read acknowledge; clears that slot's valid bit.
- Data_out_0  output  WIDTH  slot 0 register.
- Data_out_1  output  WIDTH  slot 1 register.
- Data_out_2  output  WIDTH  slot 2 register.
- Data_out_3  output  WIDTH  slot 3 register.
- valid  output  4  valid[i]=1 when slot i holds unconsumed data.
- busy  output  1  1 while the burst FSM is in BURST.
- done  output  1  one-cycle pulse on the cycle after the last burst word is written.

Behaviour:
- Reset (synchronous, sampled on the clk edge with reset=1):
  - Data_out_0..3 = 0, valid = 4'b0000, busy = 0, done = 0.
  - FSM to IDLE, burst counter = 0.
  - Overrides every other input that cycle, including mid-burst: the burst is abandoned and partial data cleared.
- Single load, IDLE only:
  - load=1 at edge N: slot[selector] = Data_in, valid[selector] = 1.
  - Visible on outputs after edge N (1-cycle latency).
  - Other slots unchanged.
- FSM states IDLE, BURST:
  - IDLE -> BURST: on burst=1. Counter = 0; this same edge writes Data_in to slot 0 and the counter advances to 1.
  - If load and burst are both high in IDLE, burst wins and load is dropped.
  - BURST: each edge writes Data_in to slot[counter] and sets its valid bit. Counter increments; selector and load are ignored.
  - After slot 3 is written: return to IDLE, counter wraps to 0, done=1 for exactly the next cycle.
  - busy=1 from the edge that enters BURST until the edge that returns to IDLE. A burst therefore occupies edges N..N+3, busy is high for 3 cycles, and done is high in cycle N+4.
  - burst=1 while busy is ignored (no restart).
- Consume:
  - consume[i]=1 clears valid[i] at the edge; Data_out_i keeps its value.
  - A write and a consume to the same slot at the same edge: the write wins and valid stays 1.
  - consume is honoured in both states.
- Overwrite of a valid slot is permitted and silently replaces the data (see Optional Feature).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro DEMUX_OVERWRITE_ERR_EN.
- When defined:
  - Adds output overwrite_err (1 bit, reset 0).
  - Sticky: set at any edge where a write (single or burst) targets a slot whose valid bit was 1 and which is not consumed at that same edge.
  - Cleared only by reset.
- When undefined: the port does not exist and overwrites are silent.

Test Plan:
- Reset: apply reset for 2 cycles after random loads -> all Data_out = 0, valid = 0000, busy = 0, done = 0.
- Single loads: load with selector=2, Data_in=32'hDEADBEEF -> next cycle Data_out_2 = DEADBEEF, valid = 0100, other slots 0. Then consume = 0100 -> valid = 0000 and Data_out_2 still DEADBEEF.
- Burst: burst=1 with Data_in = 11, 22, 33, 44 on 4 consecutive edges -> Data_out_0..3 = 11, 22, 33, 44, valid = 1111. busy high for 3 cycles, done pulses once on the cycle after the 4th write. load=1 with selector=0 and Data_in=99 during the burst -> slot 0 remains 11.
- Simultaneous events: load and burst together in IDLE -> burst taken. Write plus consume to the same slot at one edge -> valid stays 1.
- Reset mid-burst: assert reset after 2 burst words -> all cleared, FSM in IDLE, no done pulse. A fresh burst afterwards completes normally.
- With DEMUX_OVERWRITE_ERR_EN: load slot 1 twice without a consume -> overwrite_err = 1 after the second edge and stays 1 until reset. Load/consume/load sequence -> overwrite_err stays 0.
